// File: rtl/srt_quotient_converter_if.sv
// Handshake/bus bundle between the SRT digit generator, this converter and writeback.
// The master drives the digit stream and operation setup; the slave returns results.
interface srt_quotient_converter_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            neg_q;
  logic            neg_r;
  logic [4:0]      rem_shift;
  logic [XLEN-1:0] divisor;
  logic            digit_valid;
  logic [1:0]      digit;
  logic [1:0]      skip_amt;
  logic            last;
  logic [XLEN-1:0] rem_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;

  modport master (
    output start, neg_q, neg_r, rem_shift, divisor,
    output digit_valid, digit, skip_amt, last, rem_in,
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  start, neg_q, neg_r, rem_shift, divisor,
    input  digit_valid, digit, skip_amt, last, rem_in,
    output busy, done, quotient, remainder
  );
endinterface

// File: rtl/srt_quotient_converter.sv
// On-the-fly conversion of the SRT redundant digit stream into a binary quotient,
// followed by negative-remainder correction, remainder de-normalisation and sign fix-up.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | waiting for start; results held
// S_ACCUM   | absorbing digit beats into Q/QM; last beat latches rem_in
// S_CORRECT | negative remainder: add divisor back and select QM as quotient
// S_FIXUP   | de-normalise remainder, apply signs, register results, pulse done
module srt_quotient_converter #(
  parameter int XLEN = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  srt_quotient_converter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_CORRECT,
    S_FIXUP
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] q_q, q_d;
  logic [XLEN-1:0] qm_q, qm_d;
  logic [XLEN-1:0] r_q, r_d;
  logic [XLEN-1:0] quotient_q, quotient_d;
  logic [XLEN-1:0] remainder_q, remainder_d;
  logic            done_q, done_d;

  logic            neg_q_q;
  logic            neg_r_q;
  logic [4:0]      rem_shift_q;
  logic [XLEN-1:0] divisor_q;

  logic [XLEN-1:0] beat_q;
  logic [XLEN-1:0] beat_qm;
  logic [XLEN-1:0] rem_shifted;

  // Returns {Q', QM'} for one appended digit; the illegal code 10 behaves as zero.
  function automatic logic [2*XLEN-1:0] append_digit(
    input logic [XLEN-1:0] q,
    input logic [XLEN-1:0] qm,
    input logic [1:0]      d
  );
    logic [XLEN-1:0] nq;
    logic [XLEN-1:0] nqm;
    case (d)
      2'b01: begin
        nq  = {q[XLEN-2:0], 1'b1};
        nqm = {q[XLEN-2:0], 1'b0};
      end
      2'b11: begin
        nq  = {qm[XLEN-2:0], 1'b1};
        nqm = {qm[XLEN-2:0], 1'b0};
      end
      default: begin
        nq  = {q[XLEN-2:0], 1'b0};
        nqm = {qm[XLEN-2:0], 1'b1};
      end
    endcase
    return {nq, nqm};
  endfunction

  // Up to three skipped zero digits plus the beat's own digit, all in one cycle.
  always_comb begin
    beat_q  = q_q;
    beat_qm = qm_q;
    if (bus.skip_amt > 2'd0) {beat_q, beat_qm} = append_digit(beat_q, beat_qm, 2'b00);
    if (bus.skip_amt > 2'd1) {beat_q, beat_qm} = append_digit(beat_q, beat_qm, 2'b00);
    if (bus.skip_amt > 2'd2) {beat_q, beat_qm} = append_digit(beat_q, beat_qm, 2'b00);
    {beat_q, beat_qm} = append_digit(beat_q, beat_qm, bus.digit);
  end

  assign rem_shifted = r_q >> rem_shift_q;

  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    qm_d        = qm_q;
    r_d         = r_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    done_d      = 1'b0;

    case (state_q)
      S_ACCUM: begin
        if (bus.digit_valid) begin
          q_d  = beat_q;
          qm_d = beat_qm;
          if (bus.last) begin
            r_d     = bus.rem_in;
            state_d = S_CORRECT;
          end
        end
      end
      S_CORRECT: begin
        if (r_q[XLEN-1]) begin
          r_d = r_q + divisor_q;
          q_d = qm_q;
        end
        state_d = S_FIXUP;
      end
      S_FIXUP: begin
        quotient_d  = neg_q_q ? -q_q : q_q;
        remainder_d = neg_r_q ? -rem_shifted : rem_shifted;
        done_d      = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = state_q;
    endcase

    // A new start aborts whatever is in flight, including a pending fix-up.
    if (bus.start) begin
      state_d     = S_ACCUM;
      q_d         = '0;
      qm_d        = '0;
      r_d         = '0;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      q_q         <= '0;
      qm_q        <= '0;
      r_q         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      rem_shift_q <= '0;
      divisor_q   <= '0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      qm_q        <= qm_d;
      r_q         <= r_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
      if (bus.start) begin
        neg_q_q     <= bus.neg_q;
        neg_r_q     <= bus.neg_r;
        rem_shift_q <= bus.rem_shift;
        divisor_q   <= bus.divisor;
      end
    end
  end

  // busy stays up through the done cycle, then drops with it.
  assign bus.busy      = (state_q != S_IDLE) | done_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;

endmodule

// File: tb/tb_srt_quotient_converter.sv
// Directed bench for srt_quotient_converter: hand-computed quotient/remainder vectors,
// done latency, abort by restart and reset during correction.
module tb_srt_quotient_converter;

  localparam int XLEN = 32;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  int   done_cnt;
  int   done_ref;

  srt_quotient_converter_if #(.XLEN(XLEN)) bus ();

  srt_quotient_converter #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) if (bus.done) done_cnt++;

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op_start(input logic nq, input logic nr, input logic [4:0] sh,
                          input logic [XLEN-1:0] dv);
    bus.start     = 1'b1;
    bus.neg_q     = nq;
    bus.neg_r     = nr;
    bus.rem_shift = sh;
    bus.divisor   = dv;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic beat(input logic [1:0] d, input logic [1:0] sk, input logic lst,
                      input logic [XLEN-1:0] rem);
    bus.digit_valid = 1'b1;
    bus.digit       = d;
    bus.skip_amt    = sk;
    bus.last        = lst;
    bus.rem_in      = rem;
    tick();
    bus.digit_valid = 1'b0;
    bus.digit       = 2'b00;
    bus.skip_amt    = 2'd0;
    bus.last        = 1'b0;
    bus.rem_in      = '0;
  endtask

  // Called just after the edge that accepted the last beat: done must arrive 3 cycles later.
  task automatic expect_result(input string tag, input logic [XLEN-1:0] q_exp,
                               input logic [XLEN-1:0] r_exp);
    chk({tag, "_done_c1"}, {31'b0, bus.done}, 32'd0);
    chk({tag, "_busy_c1"}, {31'b0, bus.busy}, 32'd1);
    tick();
    chk({tag, "_done_c2"}, {31'b0, bus.done}, 32'd0);
    tick();
    chk({tag, "_done_c3"}, {31'b0, bus.done}, 32'd1);
    chk({tag, "_busy_c3"}, {31'b0, bus.busy}, 32'd1);
    chk({tag, "_quot"}, bus.quotient, q_exp);
    chk({tag, "_rem"}, bus.remainder, r_exp);
    tick();
    chk({tag, "_done_off"}, {31'b0, bus.done}, 32'd0);
    chk({tag, "_busy_off"}, {31'b0, bus.busy}, 32'd0);
    chk({tag, "_quot_hold"}, bus.quotient, q_exp);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    done_cnt = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.neg_q = 1'b0;
    bus.neg_r = 1'b0;
    bus.rem_shift = 5'd0;
    bus.divisor = '0;
    bus.digit_valid = 1'b0;
    bus.digit = 2'b00;
    bus.skip_amt = 2'd0;
    bus.last = 1'b0;
    bus.rem_in = '0;
    repeat (2) tick();
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_quot", bus.quotient, 32'd0);
    chk("rst_rem", bus.remainder, 32'd0);
    reset = 1'b0;
    tick();

    // 1: +1,0,+1 -> 101b = 5, remainder 1
    op_start(1'b0, 1'b0, 5'd0, 32'd0);
    chk("t1_busy_start", {31'b0, bus.busy}, 32'd1);
    beat(2'b01, 2'd0, 1'b0, 32'd0);
    beat(2'b00, 2'd0, 1'b0, 32'd0);
    beat(2'b01, 2'd0, 1'b1, 32'd1);
    expect_result("t1", 32'd5, 32'd1);

    // 2: +1,-1,0,-1 -> 8-4-1 = 3
    op_start(1'b0, 1'b0, 5'd0, 32'd7);
    beat(2'b01, 2'd0, 1'b0, 32'd0);
    beat(2'b11, 2'd0, 1'b0, 32'd0);
    beat(2'b00, 2'd0, 1'b0, 32'd0);
    beat(2'b11, 2'd0, 1'b1, 32'd0);
    expect_result("t2", 32'd3, 32'd0);

    // 3: skip 3 then +1, then 0 -> 00010b = 2
    op_start(1'b0, 1'b0, 5'd0, 32'd0);
    beat(2'b01, 2'd3, 1'b0, 32'd0);
    beat(2'b00, 2'd0, 1'b1, 32'd0);
    expect_result("t3", 32'd2, 32'd0);

    // 4: Q=3, R=-2 -> correction: Q=2, R=-2+5=3
    op_start(1'b0, 1'b0, 5'd0, 32'd5);
    beat(2'b01, 2'd0, 1'b0, 32'd0);
    beat(2'b01, 2'd0, 1'b1, 32'hFFFF_FFFE);
    expect_result("t4", 32'd2, 32'd3);

    // 5a: case 1 negated
    op_start(1'b1, 1'b1, 5'd0, 32'd0);
    beat(2'b01, 2'd0, 1'b0, 32'd0);
    beat(2'b00, 2'd0, 1'b0, 32'd0);
    beat(2'b01, 2'd0, 1'b1, 32'd1);
    expect_result("t5a", 32'hFFFF_FFFB, 32'hFFFF_FFFF);

    // 5b: remainder 8 >> 2 = 2
    op_start(1'b0, 1'b0, 5'd2, 32'd0);
    beat(2'b01, 2'd0, 1'b1, 32'd8);
    expect_result("t5b", 32'd1, 32'd2);

    // 7: illegal digit 10 acts as 0; beats offered after last are ignored
    op_start(1'b0, 1'b0, 5'd0, 32'd0);
    beat(2'b10, 2'd0, 1'b0, 32'd0);
    bus.digit_valid = 1'b1;
    bus.digit = 2'b01;
    bus.last = 1'b1;
    bus.rem_in = 32'd4;
    tick();
    expect_result("t7", 32'd1, 32'd4);
    bus.digit_valid = 1'b0;
    bus.digit = 2'b00;
    bus.last = 1'b0;
    bus.rem_in = '0;

    // 6a: restart mid-ACCUM aborts the first op; only one done pulse
    done_ref = done_cnt;
    op_start(1'b0, 1'b0, 5'd0, 32'd0);
    beat(2'b01, 2'd0, 1'b0, 32'd0);
    beat(2'b01, 2'd0, 1'b0, 32'd0);
    op_start(1'b0, 1'b0, 5'd0, 32'd0);
    chk("t6_quot_held", bus.quotient, 32'd1);
    beat(2'b01, 2'd0, 1'b0, 32'd0);
    beat(2'b00, 2'd0, 1'b0, 32'd0);
    beat(2'b01, 2'd0, 1'b1, 32'd1);
    expect_result("t6a", 32'd5, 32'd1);
    chk("t6_done_count", done_cnt, done_ref + 1);

    // 6b: reset while in CORRECT
    done_ref = done_cnt;
    op_start(1'b0, 1'b0, 5'd0, 32'd3);
    beat(2'b01, 2'd0, 1'b1, 32'hFFFF_FFFF);
    reset = 1'b1;
    tick();
    chk("t6_rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("t6_rst_done", {31'b0, bus.done}, 32'd0);
    chk("t6_rst_quot", bus.quotient, 32'd0);
    chk("t6_rst_rem", bus.remainder, 32'd0);
    reset = 1'b0;
    repeat (4) tick();
    chk("t6_rst_no_done", done_cnt, done_ref);
    chk("t6_rst_idle_busy", {31'b0, bus.busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
